// File: rtl/axi_cxl_pkg.sv
// Shared widths, queue entry layouts and the wrap-safe due test for the
// CXL far-memory stand-in model.
package axi_cxl_pkg;

    localparam int DEF_ADDR_W    = 64;
    localparam int DEF_DATA_W    = 512;
    localparam int DEF_TAG_W     = 64;
    localparam int DEF_ID_W      = 16;
    localparam int DEF_OFFSET_W  = 6;
    localparam int DEF_MEM_IDX_W = 20;
    localparam int CNT_W         = 32;

    typedef logic [CNT_W-1:0] cycle_t;

    // Entry fields are sized for the default ID and line-index widths.
    typedef struct packed {
        logic [DEF_ID_W-1:0]      id;
        logic [DEF_MEM_IDX_W-1:0] index;
        cycle_t                   due;
    } ar_entry_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]      id;
        logic [DEF_MEM_IDX_W-1:0] index;
    } aw_entry_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0] id;
        cycle_t              due;
    } b_entry_t;

    // (now - due) taken as signed keeps the test correct across counter wrap.
    function automatic logic due_reached(input cycle_t now, input cycle_t due);
        cycle_t diff;
        diff = now - due;
        return !diff[CNT_W-1];
    endfunction

endpackage

// File: rtl/axi_cxl_sync_fifo.sv
// Small synchronous FIFO with registered occupancy; head is the oldest entry.
module axi_cxl_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Fullness comes from the registered count, so a pop frees a slot only
    // on the following cycle.
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/axi_cxl_mem_model.sv
// AXI-style slave memory standing in for CXL far memory: queued AR/AW/W/B,
// fixed programmable latencies, tag-extended read data.
module axi_cxl_mem_model
    import axi_cxl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TAG_W     = DEF_TAG_W,
    parameter int ID_W      = DEF_ID_W,
    parameter int OFFSET_W  = DEF_OFFSET_W,
    parameter int MEM_IDX_W = DEF_MEM_IDX_W,
    parameter int Q_DEPTH   = 4,
    parameter int RD_LAT    = 8,
    parameter int WR_LAT    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_W-1:0]         arid_i,
    input  logic [ADDR_W-1:0]       araddr_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_W-1:0]         rid_o,
    output logic [TAG_W+DATA_W-1:0] rdata_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    input  logic [ID_W-1:0]         awid_i,
    input  logic [ADDR_W-1:0]       awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ID_W-1:0]         wid_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_W-1:0]         bid_o,
    output logic                    bvalid_o,
    input  logic                    bready_i
);

    cycle_t            now;
    ar_entry_t         ar_in;
    ar_entry_t         ar_head;
    aw_entry_t         aw_in;
    aw_entry_t         aw_head;
    b_entry_t          b_in;
    b_entry_t          b_head;
    logic [DATA_W-1:0] w_head;

    logic ar_full, ar_empty, aw_full, aw_empty;
    logic w_full, w_empty, b_full, b_empty;
    logic ar_push, r_pop, aw_push, w_push, wr_join, b_pop;
    logic unused_inputs;

    logic [DATA_W-1:0] mem [2**MEM_IDX_W];

    // The write ID is not needed (AW carries it) and only a slice of each
    // address forms the line index; high bits alias silently.
    assign unused_inputs = ^{wid_i, araddr_i, awaddr_i};

    assign arready_o = rst_n && !ar_full;
    assign awready_o = rst_n && !aw_full;
    assign wready_o  = rst_n && !w_full;

    assign ar_push = arvalid_i && arready_o;
    assign aw_push = awvalid_i && awready_o;
    assign w_push  = wvalid_i && wready_o;

    assign ar_in = '{id:    DEF_ID_W'(arid_i),
                     index: DEF_MEM_IDX_W'(araddr_i[OFFSET_W +: MEM_IDX_W]),
                     due:   now + cycle_t'(RD_LAT)};
    assign aw_in = '{id:    DEF_ID_W'(awid_i),
                     index: DEF_MEM_IDX_W'(awaddr_i[OFFSET_W +: MEM_IDX_W])};

    // Read data is looked up at the head, so a write joined in the same cycle
    // is only visible from the next cycle onward.
    assign rvalid_o = rst_n && !ar_empty && due_reached(now, ar_head.due);
    assign r_pop    = rvalid_o && rready_i;
    assign rid_o    = rvalid_o ? ID_W'(ar_head.id) : '0;
    assign rdata_o  = rvalid_o ? {{TAG_W{1'b0}}, mem[ar_head.index]} : '0;

    assign wr_join = rst_n && !aw_empty && !w_empty && !b_full;
    assign b_in    = '{id: aw_head.id, due: now + cycle_t'(WR_LAT)};

    assign bvalid_o = rst_n && !b_empty && due_reached(now, b_head.due);
    assign b_pop    = bvalid_o && bready_i;
    assign bid_o    = bvalid_o ? ID_W'(b_head.id) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            now <= '0;
        end else begin
            now <= now + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_join) begin
            mem[aw_head.index] <= w_head;
        end
    end

    axi_cxl_sync_fifo #(
        .WIDTH ($bits(ar_entry_t)),
        .DEPTH (Q_DEPTH)
    ) u_ar_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ar_push),
        .din   (ar_in),
        .pop   (r_pop),
        .full  (ar_full),
        .empty (ar_empty),
        .head  (ar_head)
    );

    axi_cxl_sync_fifo #(
        .WIDTH ($bits(aw_entry_t)),
        .DEPTH (Q_DEPTH)
    ) u_aw_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_push),
        .din   (aw_in),
        .pop   (wr_join),
        .full  (aw_full),
        .empty (aw_empty),
        .head  (aw_head)
    );

    axi_cxl_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (Q_DEPTH)
    ) u_w_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (wdata_i),
        .pop   (wr_join),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    axi_cxl_sync_fifo #(
        .WIDTH ($bits(b_entry_t)),
        .DEPTH (Q_DEPTH)
    ) u_b_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_join),
        .din   (b_in),
        .pop   (b_pop),
        .full  (b_full),
        .empty (b_empty),
        .head  (b_head)
    );

endmodule

// File: tb/tb_axi_cxl_mem_model.sv
// Bench for axi_cxl_mem_model: directed scenarios plus a random phase, all
// checked every cycle against a queue-based transaction model.
module tb_axi_cxl_mem_model;

    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 512;
    localparam int TAG_W     = 64;
    localparam int ID_W      = 16;
    localparam int OFFSET_W  = 6;
    localparam int MEM_IDX_W = 20;
    localparam int Q_DEPTH   = 4;
    localparam int RD_LAT    = 8;
    localparam int WR_LAT    = 4;
    localparam int RW        = TAG_W + DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [ID_W-1:0]   arid_i;
    logic [ADDR_W-1:0] araddr_i;
    logic              arvalid_i;
    logic              arready_o;
    logic [ID_W-1:0]   rid_o;
    logic [RW-1:0]     rdata_o;
    logic              rvalid_o;
    logic              rready_i;
    logic [ID_W-1:0]   awid_i;
    logic [ADDR_W-1:0] awaddr_i;
    logic              awvalid_i;
    logic              awready_o;
    logic [ID_W-1:0]   wid_i;
    logic [DATA_W-1:0] wdata_i;
    logic              wvalid_i;
    logic              wready_o;
    logic [ID_W-1:0]   bid_o;
    logic              bvalid_o;
    logic              bready_i;

    axi_cxl_mem_model #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .ID_W      (ID_W),
        .OFFSET_W  (OFFSET_W),
        .MEM_IDX_W (MEM_IDX_W),
        .Q_DEPTH   (Q_DEPTH),
        .RD_LAT    (RD_LAT),
        .WR_LAT    (WR_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arid_i    (arid_i),
        .araddr_i  (araddr_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rid_o     (rid_o),
        .rdata_o   (rdata_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .awid_i    (awid_i),
        .awaddr_i  (awaddr_i),
        .awvalid_i (awvalid_i),
        .awready_o (awready_o),
        .wid_i     (wid_i),
        .wdata_i   (wdata_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .bid_o     (bid_o),
        .bvalid_o  (bvalid_o),
        .bready_i  (bready_i)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: pending transactions as queues, memory as a sparse map.
    typedef struct { int id; int idx; int due; } rd_t;
    typedef struct { int id; int idx; } aw_t;
    typedef struct { int id; int due; } bq_t;

    rd_t               ar_m[$];
    aw_t               aw_m[$];
    logic [DATA_W-1:0] w_m[$];
    bq_t               b_m[$];
    logic [DATA_W-1:0] mem_m [int];

    int            obs_rid[$];
    logic [RW-1:0] obs_rdata[$];
    int            obs_bid[$];

    logic exp_arready, exp_awready, exp_wready;

    logic [DATA_W-1:0] d0, d1;

    function automatic int line_idx(input logic [ADDR_W-1:0] a);
        return int'((a >> OFFSET_W) & ((64'd1 << MEM_IDX_W) - 64'd1));
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W / 32; i++) d = {d[DATA_W-33:0], 32'($urandom())};
        return d;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] hi;
        hi = {32'($urandom()), 32'($urandom())};
        return (hi << (OFFSET_W + MEM_IDX_W)) | (64'($urandom_range(0, 15)) << OFFSET_W)
               | 64'($urandom_range(0, 63));
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, advance the model by the
    // handshakes of this cycle, then move to the next negedge.
    task automatic step();
        logic e_rv, e_bv, jn;
        #1;
        exp_arready = rst_n && (ar_m.size() < Q_DEPTH);
        exp_awready = rst_n && (aw_m.size() < Q_DEPTH);
        exp_wready  = rst_n && (w_m.size() < Q_DEPTH);
        e_rv = rst_n && (ar_m.size() > 0) && (cyc >= ar_m[0].due);
        e_bv = rst_n && (b_m.size() > 0) && (cyc >= b_m[0].due);
        jn   = rst_n && (aw_m.size() > 0) && (w_m.size() > 0) && (b_m.size() < Q_DEPTH);

        chk("arready", RW'(arready_o), RW'(exp_arready));
        chk("awready", RW'(awready_o), RW'(exp_awready));
        chk("wready",  RW'(wready_o),  RW'(exp_wready));
        chk("rvalid",  RW'(rvalid_o),  RW'(e_rv));
        chk("bvalid",  RW'(bvalid_o),  RW'(e_bv));
        if (!rst_n) begin
            chk("rid_rst",   RW'(rid_o), '0);
            chk("bid_rst",   RW'(bid_o), '0);
            chk("rdata_rst", rdata_o,    '0);
        end
        if (e_rv) begin
            chk("rid", RW'(rid_o), RW'(ar_m[0].id));
            if (mem_m.exists(ar_m[0].idx))
                chk("rdata", rdata_o, {TAG_W'(0), mem_m[ar_m[0].idx]});
        end
        if (e_bv) chk("bid", RW'(bid_o), RW'(b_m[0].id));

        if (rvalid_o && rready_i) begin
            obs_rid.push_back(int'(rid_o));
            obs_rdata.push_back(rdata_o);
        end
        if (bvalid_o && bready_i) obs_bid.push_back(int'(bid_o));

        if (!rst_n) begin
            ar_m.delete();
            aw_m.delete();
            w_m.delete();
            b_m.delete();
        end else begin
            if (e_rv && rready_i) void'(ar_m.pop_front());
            if (e_bv && bready_i) void'(b_m.pop_front());
            if (jn) begin
                mem_m[aw_m[0].idx] = w_m[0];
                b_m.push_back('{aw_m[0].id, cyc + WR_LAT});
                void'(aw_m.pop_front());
                void'(w_m.pop_front());
            end
            if (arvalid_i && exp_arready)
                ar_m.push_back('{int'(arid_i), line_idx(araddr_i), cyc + RD_LAT});
            if (awvalid_i && exp_awready)
                aw_m.push_back('{int'(awid_i), line_idx(awaddr_i)});
            if (wvalid_i && exp_wready) w_m.push_back(wdata_i);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_ar(input int id, input logic [ADDR_W-1:0] addr);
        logic done;
        done = 1'b0;
        arid_i = ID_W'(id);
        araddr_i = addr;
        arvalid_i = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            done = exp_arready;
        end
        arvalid_i = 1'b0;
        chk("ar_accept", RW'(done), RW'(1));
    endtask

    task automatic send_aw(input int id, input logic [ADDR_W-1:0] addr);
        logic done;
        done = 1'b0;
        awid_i = ID_W'(id);
        awaddr_i = addr;
        awvalid_i = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            done = exp_awready;
        end
        awvalid_i = 1'b0;
        chk("aw_accept", RW'(done), RW'(1));
    endtask

    task automatic send_w(input logic [DATA_W-1:0] data);
        logic done;
        done = 1'b0;
        wdata_i = data;
        wvalid_i = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            done = exp_wready;
        end
        wvalid_i = 1'b0;
        chk("w_accept", RW'(done), RW'(1));
    endtask

    task automatic send_wr(input int id, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        logic aw_done, w_done;
        aw_done = 1'b0;
        w_done = 1'b0;
        awid_i = ID_W'(id);
        awaddr_i = addr;
        wdata_i = data;
        awvalid_i = 1'b1;
        wvalid_i = 1'b1;
        for (int i = 0; i < 64 && !(aw_done && w_done); i++) begin
            step();
            if (exp_awready) begin aw_done = 1'b1; awvalid_i = 1'b0; end
            if (exp_wready)  begin w_done  = 1'b1; wvalid_i  = 1'b0; end
        end
        awvalid_i = 1'b0;
        wvalid_i = 1'b0;
        chk("wr_accept", RW'(aw_done && w_done), RW'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        arid_i = '0; araddr_i = '0; arvalid_i = 1'b0; rready_i = 1'b1;
        awid_i = '0; awaddr_i = '0; awvalid_i = 1'b0;
        wid_i = '0; wdata_i = '0; wvalid_i = 1'b0; bready_i = 1'b1;
        d0 = rand_data();
        d1 = rand_data();
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // 1: write then read back
        send_wr(3, 64'h1000, d0);
        idle(WR_LAT + 3);
        chk("t1_bid_count", RW'(obs_bid.size()), RW'(1));
        chk("t1_bid", RW'(obs_bid[0]), RW'(3));
        send_ar(7, 64'h1000);
        idle(RD_LAT + 2);
        chk("t1_rid_count", RW'(obs_rid.size()), RW'(1));
        chk("t1_rid", RW'(obs_rid[0]), RW'(7));
        chk("t1_rdata", obs_rdata[0], {TAG_W'(0), d0});

        // 2: back-to-back reads, then a stalled fifth
        obs_rid.delete();
        for (int i = 0; i < 4; i++) send_ar(i, 64'h1000);
        rready_i = 1'b0;
        arid_i = ID_W'(4);
        arvalid_i = 1'b1;
        idle(6);
        chk("t2_ar_stall", RW'(arready_o), RW'(0));
        rready_i = 1'b1;
        send_ar(4, 64'h1000);
        idle(RD_LAT + 6);
        chk("t2_rid_count", RW'(obs_rid.size()), RW'(5));
        for (int i = 0; i < 5; i++) chk("t2_rid_order", RW'(obs_rid[i]), RW'(i));

        // 3: W ahead of AW
        obs_bid.delete();
        send_w(d1);
        idle(5);
        chk("t3_no_b", RW'(bvalid_o), RW'(0));
        send_aw(9, 64'h40);
        idle(WR_LAT + 3);
        chk("t3_bid_count", RW'(obs_bid.size()), RW'(1));
        chk("t3_bid", RW'(obs_bid[0]), RW'(9));

        // 4: aliased read of index 1
        obs_rdata.delete();
        send_ar(21, 64'h40 + (64'd1 << (MEM_IDX_W + OFFSET_W)));
        idle(RD_LAT + 2);
        chk("t4_count", RW'(obs_rdata.size()), RW'(1));
        chk("t4_alias_data", obs_rdata[0], {TAG_W'(0), d1});

        // 5: B back-pressure fills every write queue
        obs_bid.delete();
        bready_i = 1'b0;
        for (int k = 0; k < 2 * Q_DEPTH; k++) send_wr(20 + k, 64'h2000 + 64'(k * 64), rand_data());
        awvalid_i = 1'b1;
        wvalid_i = 1'b1;
        awid_i = ID_W'(99);
        idle(5);
        chk("t5_awready_full", RW'(awready_o), RW'(0));
        chk("t5_wready_full",  RW'(wready_o),  RW'(0));
        awvalid_i = 1'b0;
        wvalid_i = 1'b0;
        bready_i = 1'b1;
        idle(30);
        chk("t5_bid_count", RW'(obs_bid.size()), RW'(2 * Q_DEPTH));
        for (int k = 0; k < 2 * Q_DEPTH; k++) chk("t5_bid_order", RW'(obs_bid[k]), RW'(20 + k));

        // 6: reset with reads in flight
        rready_i = 1'b0;
        send_ar(30, 64'h1000);
        send_ar(31, 64'h1000);
        step();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        rready_i = 1'b1;
        obs_rid.delete();
        obs_rdata.delete();
        idle(RD_LAT + 4);
        chk("t6_no_stale", RW'(obs_rid.size()), RW'(0));
        send_ar(11, 64'h1000);
        idle(RD_LAT + 2);
        chk("t6_count", RW'(obs_rid.size()), RW'(1));
        chk("t6_rid", RW'(obs_rid[0]), RW'(11));
        chk("t6_rdata", obs_rdata[0], {TAG_W'(0), d0});

        // random traffic, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            arvalid_i = ($urandom_range(0, 2) == 0);
            arid_i    = ID_W'($urandom());
            araddr_i  = rand_addr();
            awvalid_i = ($urandom_range(0, 2) == 0);
            awid_i    = ID_W'($urandom());
            awaddr_i  = rand_addr();
            wvalid_i  = ($urandom_range(0, 2) == 0);
            wid_i     = ID_W'($urandom());
            wdata_i   = rand_data();
            rready_i  = ($urandom_range(0, 3) != 0);
            bready_i  = ($urandom_range(0, 3) != 0);
            step();
        end
        arvalid_i = 1'b0;
        awvalid_i = 1'b0;
        wvalid_i = 1'b0;
        rready_i = 1'b1;
        bready_i = 1'b1;
        idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
